// File: rtl/sisc_pkg.sv
// Shared SISC definitions: arbiter FSM encoding, port identifiers and the
// latency-counter width.
package sisc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Two-requester round-robin picker: a lone requester wins; under contention
// the port that did not win last time gets the grant.
module rr_pick
  import sisc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_win,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_IF;
    if (req[PORT_DM] && (!req[PORT_IF] || (last_win == PORT_IF))) begin
      gnt_id = PORT_DM;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Fetch/data arbiter in front of one single-port, fixed-latency memory.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one rdy pulse).
module mem_arb
  import sisc_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_rdy,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_rdy,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             port;
  logic             last_win;
  logic             gnt_valid, gnt_id;
  logic             grant, done;

  rr_pick u_pick (
    .req      ({dm_req, if_req}),
    .last_win (last_win),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          grant   = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          done    = 1'b1;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latch, memory drive, read capture and rdy pulses.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt       <= '0;
      port      <= PORT_IF;
      last_win  <= PORT_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_rdy    <= 1'b0;
      dm_rdy    <= 1'b0;
    end else begin
      if_rdy <= done && (port == PORT_IF);
      dm_rdy <= done && (port == PORT_DM);
      if (grant) begin
        port      <= gnt_id;
        cnt       <= CNT_W'(MEM_LAT - 1);
        mem_en    <= 1'b1;
        mem_we    <= (gnt_id == PORT_DM) && dm_we;
        mem_addr  <= (gnt_id == PORT_DM) ? dm_addr : if_addr;
        mem_wdata <= (gnt_id == PORT_DM) ? dm_wdata : '0;
      end else if (done) begin
        mem_en   <= 1'b0;
        mem_we   <= 1'b0;
        last_win <= port;
        if (!mem_we) begin
          if (port == PORT_IF) if_rdata <= mem_rdata;
          else                 dm_rdata <= mem_rdata;
        end
      end else if (state == ACCESS) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a MEM_LAT=2 instance against a latency-accurate
// memory model, plus a MEM_LAT=1 instance against a decode-only memory.
module tb_mem_arb;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic        dm;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        if_rdy, dm_rdy, mem_en, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  logic        if_req1 = 1'b0, dm_req1 = 1'b0;
  logic [15:0] if_addr1 = '0, dm_addr1 = '0;
  logic        if_rdy1, dm_rdy1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
  logic [15:0] mem_addr1;

  int checks = 0;
  int failures = 0;

  mem_arb #(.AW(16), .DW(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdy(dm_rdy), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arb #(.AW(16), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdy(if_rdy1), .if_rdata(if_rdata1),
    .dm_req(dm_req1), .dm_we(1'b0), .dm_addr(dm_addr1), .dm_wdata(32'h0),
    .dm_rdy(dm_rdy1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  // Memory model: read data is valid only in the LAT-th cycle of mem_en.
  logic [31:0] mem_arr [0:63];
  logic        preload = 1'b0;
  int unsigned en_cyc;

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f)      en_cyc <= 0;
    else if (mem_en) en_cyc <= en_cyc + 1;
    else             en_cyc <= 0;
  end

  always @(posedge clk) begin
    if (preload) begin
      mem_arr[4]  <= 32'h88001234;
      mem_arr[8]  <= 32'h12345678;
      mem_arr[60] <= 32'h0BADF00D;
    end else if (mem_en && mem_we && en_cyc == 32'(LAT - 1)) begin
      mem_arr[mem_addr[5:0]] <= mem_wdata;
    end
  end

  assign mem_rdata  = (mem_en && en_cyc == 32'(LAT - 1)) ? mem_arr[mem_addr[5:0]] : 32'hBAD0BAD0;
  assign mem_rdata1 = mem_en1 ? {16'hA5A5, mem_addr1} : 32'hBAD0BAD0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Caller is at a negedge in an IDLE cycle; returns at a negedge in IDLE.
  task automatic run_txn(input vec_t v, input int idx);
    int lat, en_n, we_n, bad, other;
    bit seen;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    lat = 0; en_n = 0; we_n = 0; bad = 0; other = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        en_n++;
        if (mem_we) we_n++;
        if (mem_addr !== v.addr || (v.we && mem_wdata !== v.wdata)) bad++;
      end
      if (v.dm ? if_rdy : dm_rdy) other++;
      if (v.dm ? dm_rdy : if_rdy) seen = 1'b1;
    end
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    check({tag, " rdy_latency"}, 32'(lat), 32'(LAT + 1));
    check({tag, " mem_en_cycles"}, 32'(en_n), 32'(LAT));
    check({tag, " mem_we_cycles"}, 32'(we_n), v.we ? 32'(LAT) : 32'd0);
    check({tag, " mem_addr_wdata_stable"}, 32'(bad), 32'd0);
    check({tag, " other_port_rdy"}, 32'(other), 32'd0);
    @(negedge clk);
    check({tag, " rdy_single_pulse"}, {31'd0, v.dm ? dm_rdy : if_rdy}, 32'd0);
    check({tag, " rdata"}, v.dm ? dm_rdata : if_rdata, v.exp_rd);
  endtask

  vec_t vecs [8];

  initial begin
    int r1, r2, bad, spur, n;
    logic [31:0] d1, d2;
    logic [31:0] ev_cyc [4];
    logic        ev_port [4];
    logic [31:0] ev_data [4];

    vecs[0] = '{1'b0, 1'b0, 16'h0004, 32'h0,        32'h88001234};
    vecs[1] = '{1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 16'h0008, 32'h0,        32'h12345678};
    vecs[5] = '{1'b1, 1'b1, 16'h0008, 32'hCAFEF00D, 32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 16'h0008, 32'h0,        32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b0, 16'h003C, 32'h0,        32'h0BADF00D};

    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    check("reset mem_en", {31'd0, mem_en}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", {16'd0, mem_addr}, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset rdy", {30'd0, if_rdy, dm_rdy}, 32'd0);
    check("reset if_rdata", if_rdata, 32'd0);
    check("reset dm_rdata", dm_rdata, 32'd0);
    @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // Address change during ACCESS is ignored; held fetch re-granted after IDLE.
    if_req = 1'b1; if_addr = 16'h0004;
    r1 = 0; r2 = 0; bad = 0; d1 = '0; d2 = '0; spur = 0;
    for (int c = 1; c <= 20 && r2 == 0; c++) begin
      @(negedge clk);
      if (mem_en && mem_addr !== ((c <= LAT) ? 16'h0004 : 16'h0010)) bad++;
      if (dm_rdy) spur++;
      if (if_rdy) begin
        if (r1 == 0) begin r1 = c; d1 = if_rdata; end
        else begin r2 = c; d2 = if_rdata; end
      end
      if (c == 1) if_addr = 16'h0010;
    end
    if_req = 1'b0;
    check("hold first_rdy_cycle", 32'(r1), 32'd3);
    check("hold second_rdy_cycle", 32'(r2), 32'd7);
    check("hold first_rdata", d1, 32'h88001234);
    check("hold second_rdata", d2, 32'hDEADBEEF);
    check("hold latched_mem_addr", 32'(bad), 32'd0);
    check("hold dm_rdy_spurious", 32'(spur), 32'd0);
    @(negedge clk);

    // Contention straight out of reset: DM, IF, DM, IF every LAT+2 cycles.
    rst_f = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    if_req = 1'b1; if_addr = 16'h0004;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0008;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (if_rdy || dm_rdy) begin
        ev_cyc[n]  = 32'(c);
        ev_port[n] = dm_rdy;
        ev_data[n] = dm_rdy ? dm_rdata : if_rdata;
        n++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("contend events", 32'(n), 32'd4);
    for (int k = 0; k < n; k++) begin
      check($sformatf("contend round%0d port", k), {31'd0, ev_port[k]}, {31'd0, k % 2 == 0});
      check($sformatf("contend round%0d cycle", k), ev_cyc[k], 32'(3 + 4 * k));
      check($sformatf("contend round%0d rdata", k), ev_data[k],
            (k % 2 == 0) ? 32'hCAFEF00D : 32'h88001234);
    end
    @(negedge clk);

    // Reset in the middle of an access clears everything with no rdy.
    if_req = 1'b1; if_addr = 16'h003C;
    @(negedge clk);
    check("midrst mem_en_before", {31'd0, mem_en}, 32'd1);
    #2 rst_f = 1'b0;
    #1;
    check("midrst mem_en", {31'd0, mem_en}, 32'd0);
    check("midrst mem_addr", {16'd0, mem_addr}, 32'd0);
    check("midrst if_rdata", if_rdata, 32'd0);
    check("midrst dm_rdata", dm_rdata, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    spur = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_rdy || dm_rdy || mem_en) spur++;
    end
    check("midrst no_activity", 32'(spur), 32'd0);
    run_txn(vecs[0], 8);

    // MEM_LAT=1 instance: rdy two cycles after the request cycle.
    for (int k = 0; k < 2; k++) begin
      int lat, en_n;
      bit seen;
      logic [15:0] a;
      a = (k == 1) ? 16'h0031 : 16'h0020;
      if (k == 1) begin dm_req1 = 1'b1; dm_addr1 = a; end
      else begin if_req1 = 1'b1; if_addr1 = a; end
      lat = 0; en_n = 0; seen = 1'b0;
      while (!seen && lat < 20) begin
        @(negedge clk);
        lat++;
        if (mem_en1) en_n++;
        if (mem_we1) en_n += 100;
        if ((k == 1) ? dm_rdy1 : if_rdy1) seen = 1'b1;
      end
      if_req1 = 1'b0; dm_req1 = 1'b0;
      check($sformatf("lat1 txn%0d latency", k), 32'(lat), 32'd2);
      check($sformatf("lat1 txn%0d mem_en_cycles", k), 32'(en_n), 32'd1);
      check($sformatf("lat1 txn%0d rdata", k), (k == 1) ? dm_rdata1 : if_rdata1, {16'hA5A5, a});
      @(negedge clk);
    end
    check("lat1 mem_wdata", mem_wdata1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port memory arbiter for the SISC processor: shares one single-port unified memory between the instruction-fetch port (PC/IR path) and the data port (load/store path). It serializes accesses with a request/ready handshake, drives the fixed-latency memory, and returns read data to the winning port. Under contention, grants alternate round-robin so neither fetch nor data starves.

## Interface
Parameters:
- AW, 16, address width (matches PC width)
- DW, 32, data width (matches instruction/register width)
- MEM_LAT, 2, memory read latency in cycles, legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst_f  in  1  reset; one clock; reset is asynchronous and active-low
- if_req  in  1  fetch request, held high until if_rdy
- if_addr  in  AW  fetch address, stable while if_req high
- if_rdy  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DW  fetched word, registered
- dm_req  in  1  data request, held high until dm_rdy
- dm_we  in  1  1 = write, 0 = read, stable while dm_req high
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdy  out  1  one-cycle pulse: data access complete
- dm_rdata  out  DW  read word, registered
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in the MEM_LAT-th cycle of mem_en

## Operation
- FSM states IDLE, ACCESS, RESP.
- IDLE: sample if_req/dm_req. None -> stay. One -> grant it. Both -> grant the port that did NOT win last (last_win register). Grant latches port id, addr, we (0 for fetch), wdata; cnt <= MEM_LAT-1; -> ACCESS.
- ACCESS: mem_en=1, mem_addr/mem_we/mem_wdata from latched values, constant for all ACCESS cycles. cnt decrements each cycle; at cnt==0 capture mem_rdata into the granted port's rdata register (reads only), update last_win, -> RESP.
- RESP: assert rdy of granted port for exactly one cycle; -> IDLE. mem_en=0.
- Writes: dm_rdy pulses as for reads; dm_rdata unchanged.
- Inputs are sampled only at the IDLE->ACCESS edge; req/addr changes during ACCESS/RESP are ignored. Dropping req after grant does not cancel the access.
- The requester may raise the next request on the edge that ends RESP; it is seen in the following IDLE cycle. No back-to-back grant without an IDLE cycle.
- if_rdata/dm_rdata hold their value until the next read completes on that port.

## Timing
- Reset (async, rst_f=0): state IDLE, if_rdy=dm_rdy=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=dm_rdata=0, cnt=0, last_win=fetch (the first contention goes to data). Reset mid-ACCESS aborts with no rdy pulse; a partial write has undefined memory effect.
- Latency: req high in IDLE cycle t -> ACCESS cycles t+1..t+MEM_LAT -> rdy high in cycle t+MEM_LAT+1.
- Throughput: one access per MEM_LAT+2 cycles; sustained contention alternates fetch/data strictly.
- MEM_LAT=1: ACCESS lasts a single cycle, capture in that cycle.
- All outputs are registered or decoded from state only; no combinational path from req to any output.

## Structure
- Shared package sisc_pkg: state encoding (IDLE, ACCESS, RESP), port-id constants PORT_IF=0 and PORT_DM=1.
- Sub-module rr_pick: combinational two-requester round-robin picker (inputs req[1:0], last_win; outputs gnt_valid, gnt_id). All remaining logic lives in mem_arb.

## Test plan
- Single fetch, MEM_LAT=2, if_addr=16'h0004, memory returns 32'h88001234 -> mem_en high 2 cycles, if_rdy pulses 3 cycles after the req cycle, if_rdata=32'h88001234; dm_rdy stays 0.
- Data write dm_addr=16'h0010, dm_wdata=32'hDEADBEEF -> mem_we=1 for both ACCESS cycles, dm_rdy single pulse, dm_rdata unchanged.
- Both requests in the same cycle from reset -> data is granted first, fetch second, then alternation over 4 back-to-back contending rounds (DM, IF, DM, IF).
- Reset asserted mid-ACCESS -> all outputs 0 immediately; no rdy pulse; after release, a fresh fetch completes normally.
- if_addr changed during ACCESS -> mem_addr keeps the latched address; fetch held high across RESP is re-granted only after one IDLE cycle.
- MEM_LAT=1 build: rdy arrives 2 cycles after the req cycle; read data is correct.
